// File: rtl/wb_stack_unit_pkg.sv
// -----------------------------------------------------------------------------
// wb_stack_unit_pkg
// Shared definitions for the LIFO stack unit:
//   - default data width and depth
//   - status FSM state encoding
//   - derived count width (log2(DEPTH)+1, enough to hold the value DEPTH)
// -----------------------------------------------------------------------------
package wb_stack_unit_pkg;

    localparam int DATA_LEN_DEF = 8;
    localparam int DEPTH_DEF    = 16;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // The count must represent 0..DEPTH inclusive, hence one bit more than the address.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(DEPTH_DEF);

endpackage

// File: rtl/wb_stack_ram.sv
// -----------------------------------------------------------------------------
// wb_stack_ram
// DEPTH x DATA_LEN storage for the stack. Contents are never reset.
// Ports:
//   clk        clock, write happens on the rising edge
//   i_we       write enable
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address (combinational read)
//   o_rd_data  read data
// -----------------------------------------------------------------------------
module wb_stack_ram
    import wb_stack_unit_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [DATA_LEN-1:0] i_wr_data,
    input  logic [AW-1:0]       i_rd_addr,
    output logic [DATA_LEN-1:0] o_rd_data
);

    logic [DATA_LEN-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/wb_stack_unit.sv
// -----------------------------------------------------------------------------
// wb_stack_unit
// LIFO stack with registered top-of-stack output, status FSM and sticky
// error flags.
// Ports:
//   clk           clock
//   rstn          asynchronous active-low reset
//   stk_push      push request (only a clean 1 counts as active)
//   stk_pop       pop request  (only a clean 1 counts as active)
//   stk_data_in   word to push
//   stk_data_out  registered top-of-stack word (0 when empty)
//   count         number of valid entries
//   empty / full  status decoded from the FSM state
//   ack           one-cycle pulse after each accepted push, pop or replace
//   overflow      sticky: a push was dropped on a full stack
//   underflow     sticky: a pop was attempted on an empty stack
//   clr_err       synchronous clear of both sticky flags
// -----------------------------------------------------------------------------
module wb_stack_unit
    import wb_stack_unit_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int CNT_W   = cnt_width(DEPTH),
    localparam int AW      = CNT_W - 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                stk_push,
    input  logic                stk_pop,
    input  logic [DATA_LEN-1:0] stk_data_in,
    output logic [DATA_LEN-1:0] stk_data_out,
    output logic [CNT_W-1:0]    count,
    output logic                empty,
    output logic                full,
    output logic                ack,
    output logic                overflow,
    output logic                underflow,
    input  logic                clr_err
);

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_count, w_count_next;
    logic [DATA_LEN-1:0] r_data_out, w_data_out_next;
    logic                r_ack, w_ack_next;
    logic                r_ovf, w_ovf_next;
    logic                r_unf, w_unf_next;

    logic                w_push, w_pop;
    logic                w_we;
    logic [AW-1:0]       w_wr_addr;
    logic [AW-1:0]       w_rd_addr;
    logic [DATA_LEN-1:0] w_rd_data;

    // The controller floats its request lines when idle, so x/z must read as 0.
    assign w_push = (stk_push === 1'b1);
    assign w_pop  = (stk_pop  === 1'b1);

    // Entry just below the current top; it becomes the new top after a pop.
    assign w_rd_addr = r_count[AW-1:0] - AW'(2);

    wb_stack_ram #(
        .DATA_LEN (DATA_LEN),
        .DEPTH    (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (stk_data_in),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_EMPTY;
            r_count    <= '0;
            r_data_out <= '0;
            r_ack      <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_data_out <= w_data_out_next;
            r_ack      <= w_ack_next;
            r_ovf      <= w_ovf_next;
            r_unf      <= w_unf_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_data_out_next = r_data_out;
        w_ack_next      = 1'b0;
        w_we            = 1'b0;
        w_wr_addr       = r_count[AW-1:0];
        // A new error below overrides the clear, so the flag stays set.
        w_ovf_next      = clr_err ? 1'b0 : r_ovf;
        w_unf_next      = clr_err ? 1'b0 : r_unf;

        if (w_push && w_pop && r_state != S_EMPTY) begin
            // Replace the top entry in place; count and state are untouched.
            w_we            = 1'b1;
            w_wr_addr       = r_count[AW-1:0] - AW'(1);
            w_data_out_next = stk_data_in;
            w_ack_next      = 1'b1;
        end else if (w_push) begin
            // Also covers push+pop on an empty stack.
            if (r_state != S_FULL) begin
                w_we            = 1'b1;
                w_count_next    = r_count + CNT_W'(1);
                w_data_out_next = stk_data_in;
                w_ack_next      = 1'b1;
            end else begin
                w_ovf_next = 1'b1;
            end
        end else if (w_pop) begin
            if (r_state != S_EMPTY) begin
                w_count_next    = r_count - CNT_W'(1);
                w_data_out_next = (r_count == CNT_W'(1)) ? '0 : w_rd_data;
                w_ack_next      = 1'b1;
            end else begin
                w_unf_next = 1'b1;
            end
        end

        case (r_state)
            S_EMPTY: if (w_count_next != '0) w_state_next = S_PART;
            S_PART: begin
                if (w_count_next == CNT_W'(DEPTH)) w_state_next = S_FULL;
                else if (w_count_next == '0)       w_state_next = S_EMPTY;
            end
            S_FULL:  if (w_count_next != CNT_W'(DEPTH)) w_state_next = S_PART;
            default: w_state_next = S_EMPTY;
        endcase
    end

    assign stk_data_out = r_data_out;
    assign count        = r_count;
    assign empty        = (r_state == S_EMPTY);
    assign full         = (r_state == S_FULL);
    assign ack          = r_ack;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_wb_stack_unit.sv
module tb_wb_stack_unit;

    localparam int DL = 8;
    localparam int DP = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          stk_push, stk_pop, clr_err;
    logic [DL-1:0] stk_data_in;
    logic [DL-1:0] stk_data_out;
    logic [CW-1:0] count;
    logic          empty, full, ack, overflow, underflow;

    always #5 clk = ~clk;

    wb_stack_unit #(.DATA_LEN(DL), .DEPTH(DP)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .ack          (ack),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a plain queue of words plus the flags.
    logic [DL-1:0] m_q[$];
    bit            m_ack, m_ovf, m_unf;

    task automatic model_reset();
        m_q.delete();
        m_ack = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic [DL-1:0] d, input logic c);
        bit pa, qa, o, u;
        pa = (p === 1'b1);
        qa = (q === 1'b1);
        o = 0;
        u = 0;
        m_ack = 0;
        if (pa && qa && m_q.size() > 0) begin
            m_q[m_q.size()-1] = d;
            m_ack = 1;
        end else if (pa) begin
            if (m_q.size() < DP) begin m_q.push_back(d); m_ack = 1; end
            else o = 1;
        end else if (qa) begin
            if (m_q.size() > 0) begin void'(m_q.pop_back()); m_ack = 1; end
            else u = 1;
        end
        if (c) begin m_ovf = 0; m_unf = 0; end
        if (o) m_ovf = 1;
        if (u) m_unf = 1;
    endtask

    function automatic logic [17:0] model_vec();
        logic [DL-1:0] top;
        top = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
        return {CW'(m_q.size()), m_q.size() == 0, m_q.size() == DP, top, m_ack, m_ovf, m_unf};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {count, empty, full, stk_data_out, ack, overflow, underflow};
    endfunction

    // Drive one set of inputs, take one rising edge, sample 1 time unit later.
    task automatic cycle(input logic p, input logic q, input logic [DL-1:0] d, input logic c);
        stk_push    = p;
        stk_pop     = q;
        stk_data_in = d;
        clr_err     = c;
        @(posedge clk);
        model_step(p, q, d, c);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; stk_push = 1'b0; stk_pop = 1'b0; stk_data_in = '0; clr_err = 1'b0;
        model_reset();
        #3;
        n_total++;
        if (dut_vec() !== {5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_state got=%h want=%h", dut_vec(), {5'd0, 1'b1, 1'b0, 8'h00, 3'b000});
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_push3();
        logic [DL-1:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, vals[i], 1'b0);
            n_total++;
            if (ack !== 1'b1 || stk_data_out !== vals[i])
                $display("FAIL push3_ack got ack=%b out=%h want ack=1 out=%h", ack, stk_data_out, vals[i]);
            else n_pass++;
        end
        n_total++;
        if (count !== 5'd3 || stk_data_out !== 8'h33 || empty !== 1'b0)
            $display("FAIL push3_state got cnt=%0d out=%h empty=%b want 3/33/0", count, stk_data_out, empty);
        else n_pass++;
    endtask

    task automatic test_pop3();
        logic [DL-1:0] want [3];
        want[0] = 8'h22; want[1] = 8'h11; want[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            n_total++;
            if (stk_data_out !== want[i] || ack !== 1'b1 || underflow !== 1'b0)
                $display("FAIL pop3_%0d got out=%h ack=%b unf=%b want out=%h ack=1 unf=0",
                         i, stk_data_out, ack, underflow, want[i]);
            else n_pass++;
        end
        n_total++;
        if (empty !== 1'b1 || count !== 5'd0)
            $display("FAIL pop3_empty got empty=%b cnt=%0d want 1/0", empty, count);
        else n_pass++;
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        n_total++;
        if (ack !== 1'b0) $display("FAIL ack_idle got=%b want=0", ack);
        else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DP; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);
        n_total++;
        if (full !== 1'b1 || count !== 5'd16 || stk_data_out !== 8'h0F || overflow !== 1'b0)
            $display("FAIL full_state got full=%b cnt=%0d out=%h ovf=%b want 1/16/0f/0",
                     full, count, stk_data_out, overflow);
        else n_pass++;
        cycle(1'b1, 1'b0, 8'hAA, 1'b0);
        n_total++;
        if (overflow !== 1'b1 || ack !== 1'b0 || stk_data_out !== 8'h0F || count !== 5'd16)
            $display("FAIL overflow got ovf=%b ack=%b out=%h cnt=%0d want 1/0/0f/16",
                     overflow, ack, stk_data_out, count);
        else n_pass++;
        // Pop from full: top becomes 0x0E, full drops.
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_total++;
        if (full !== 1'b0 || stk_data_out !== 8'h0E || overflow !== 1'b1)
            $display("FAIL pop_from_full got full=%b out=%h ovf=%b want 0/0e/1", full, stk_data_out, overflow);
        else n_pass++;
        for (int i = 0; i < DP - 1; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_total++;
        if (empty !== 1'b1 || overflow !== 1'b0)
            $display("FAIL drain_clr got empty=%b ovf=%b want 1/0", empty, overflow);
        else n_pass++;
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_total++;
        if (underflow !== 1'b1 || ack !== 1'b0 || stk_data_out !== 8'h00 || count !== 5'd0)
            $display("FAIL underflow got unf=%b ack=%b out=%h cnt=%0d want 1/0/00/0",
                     underflow, ack, stk_data_out, count);
        else n_pass++;
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_total++;
        if (underflow !== 1'b0) $display("FAIL clr_err got unf=%b want=0", underflow);
        else n_pass++;
        // Clear and new error on the same edge: error wins.
        cycle(1'b0, 1'b1, 8'h00, 1'b1);
        n_total++;
        if (underflow !== 1'b1) $display("FAIL clr_vs_err got unf=%b want=1", underflow);
        else n_pass++;
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_replace();
        cycle(1'b1, 1'b0, 8'h11, 1'b0);
        cycle(1'b1, 1'b0, 8'h22, 1'b0);
        cycle(1'b1, 1'b1, 8'h55, 1'b0);
        n_total++;
        if (count !== 5'd2 || stk_data_out !== 8'h55 || ack !== 1'b1)
            $display("FAIL replace got cnt=%0d out=%h ack=%b want 2/55/1", count, stk_data_out, ack);
        else n_pass++;
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_total++;
        if (stk_data_out !== 8'h11 || count !== 5'd1)
            $display("FAIL replace_pop got out=%h cnt=%0d want 11/1", stk_data_out, count);
        else n_pass++;
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        // Push+pop on empty behaves as plain push, no underflow.
        cycle(1'b1, 1'b1, 8'h77, 1'b0);
        n_total++;
        if (count !== 5'd1 || stk_data_out !== 8'h77 || underflow !== 1'b0 || ack !== 1'b1)
            $display("FAIL pushpop_empty got cnt=%0d out=%h unf=%b ack=%b want 1/77/0/1",
                     count, stk_data_out, underflow, ack);
        else n_pass++;
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic test_float_and_async_reset();
        cycle(1'b1, 1'b0, 8'h3C, 1'b0);
        cycle(1'b1, 1'b0, 8'h4D, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle((i % 3 == 2) ? 1'bx : 1'bz, (i % 2) ? 1'bx : 1'bz, 8'($urandom), 1'b0);
            n_total++;
            if (count !== 5'd2 || ack !== 1'b0 || stk_data_out !== 8'h4D)
                $display("FAIL float_%0d got cnt=%0d ack=%b out=%h want 2/0/4d", i, count, ack, stk_data_out);
            else n_pass++;
        end
        cycle(1'b1, 1'b0, 8'h5E, 1'b0);
        // push still asserted; pull reset between edges
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        n_total++;
        if (count !== 5'd0 || empty !== 1'b1 || stk_data_out !== 8'h00 || ack !== 1'b0)
            $display("FAIL async_reset got cnt=%0d empty=%b out=%h ack=%b want 0/1/00/0",
                     count, empty, stk_data_out, ack);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b1, 1'b0, 8'h99, 1'b0);
        n_total++;
        if (count !== 5'd1 || stk_data_out !== 8'h99 || ack !== 1'b1)
            $display("FAIL post_reset_push got cnt=%0d out=%h ack=%b want 1/99/1", count, stk_data_out, ack);
        else n_pass++;
    endtask

    task automatic test_random();
        logic p, q, c;
        int   bias;
        for (int i = 0; i < 600; i++) begin
            // Alternate phases that lean toward filling and toward draining.
            bias = ((i / 40) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(99) < bias);
            q = ($urandom_range(99) < (100 - bias));
            c = ($urandom_range(15) == 0);
            cycle(p, q, 8'($urandom), c);
            n_total++;
            if (dut_vec() !== model_vec())
                $display("FAIL random_%0d got {cnt,e,f,out,ack,ovf,unf}=%h want=%h", i, dut_vec(), model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_push3();
        test_pop3();
        test_overflow();
        test_underflow();
        test_replace();
        test_float_and_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
